// File: rtl/readout_pkg.sv
// Shared types and default widths for the readout sequencer and its timer.
package readout_pkg;

  localparam int unsigned DEF_DELAY_W    = 14;
  localparam int unsigned DEF_LEN_W      = 11;
  localparam int unsigned DEF_SHOT_W     = 16;
  localparam int unsigned DEF_IQ_TIMEOUT = 64;
  localparam int unsigned DATA_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TRIG,
    DELAY,
    COLLECT,
    WAIT_IQ,
    EMIT
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] i;
    logic [DATA_W-1:0] q;
  } iq_t;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/readout_timer.sv
// Loadable saturating down-counter; zero_c flags an expired count.
module readout_timer #(
  parameter int unsigned W = 14
) (
  input  logic         clk100,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk100) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Per-shot readout control: trigger -> delay -> collect window -> IQ capture -> handshake,
// repeated for a latched number of shots.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int unsigned DELAY_W    = DEF_DELAY_W,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter int unsigned SHOT_W     = DEF_SHOT_W,
  parameter int unsigned IQ_TIMEOUT = DEF_IQ_TIMEOUT
) (
  input  logic               clk100,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] delay_time,
  input  logic [LEN_W-1:0]   sample_length,
  input  logic [SHOT_W-1:0]  num_shots,
  input  logic               iq_valid,
  input  logic [DATA_W-1:0]  i_val,
  input  logic [DATA_W-1:0]  q_val,
  output logic               start_collect,
  output logic               collecting,
  output logic               shot_valid,
  input  logic               shot_ready,
  output logic [DATA_W-1:0]  shot_i,
  output logic [DATA_W-1:0]  shot_q,
  output logic [SHOT_W-1:0]  shot_idx,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned IQ_W  = $clog2(IQ_TIMEOUT + 1);
  localparam int unsigned TMR_W = max_w(max_w(DELAY_W, LEN_W), IQ_W);

  state_e state_q, state_d;

  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SHOT_W-1:0]  shots_q, shots_d;
  logic [SHOT_W-1:0]  idx_d;
  iq_t                iq_q, iq_d;

  logic start_collect_d, collecting_d, shot_valid_d, busy_d, done_d, error_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero_c;

  logic [TMR_W-1:0] collect_val_c;
  logic [TMR_W-1:0] delay_val_c;
  logic             last_shot_c;

  // A zero-length window still collects for one cycle, so the timer holds max(len,1)-1.
  assign collect_val_c = (len_q == '0) ? '0 : TMR_W'(len_q - LEN_W'(1));
  assign delay_val_c   = TMR_W'(delay_q - DELAY_W'(1));
  assign last_shot_c   = (shot_idx == shots_q - SHOT_W'(1));

  readout_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk100  (clk100),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero_c  (tmr_zero_c)
  );

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (arm && (num_shots != '0)) state_d = WAIT_TRIG;
        WAIT_TRIG: if (trigger) state_d = (delay_q == '0) ? COLLECT : DELAY;
        DELAY:     if (tmr_zero_c) state_d = COLLECT;
        COLLECT:   if (tmr_zero_c) state_d = WAIT_IQ;
        WAIT_IQ: begin
          if (iq_valid)        state_d = EMIT;
          else if (tmr_zero_c) state_d = IDLE;
        end
        EMIT:      if (shot_ready) state_d = last_shot_c ? IDLE : WAIT_TRIG;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Datapath and timer control; every registered output's next value is formed here.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    delay_d  = delay_q;
    len_d    = len_q;
    shots_d  = shots_q;
    iq_d     = iq_q;
    idx_d    = shot_idx;
    error_d  = error;
    done_d   = 1'b0;
    if (!abort) begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            delay_d = delay_time;
            len_d   = sample_length;
            shots_d = num_shots;
            idx_d   = '0;
            error_d = 1'b0;
            done_d  = (num_shots == '0);
          end
        end
        WAIT_TRIG: begin
          if (trigger) begin
            tmr_load = 1'b1;
            tmr_val  = (delay_q == '0) ? collect_val_c : delay_val_c;
          end
        end
        DELAY: begin
          if (tmr_zero_c) begin
            tmr_load = 1'b1;
            tmr_val  = collect_val_c;
          end
        end
        COLLECT: begin
          if (tmr_zero_c) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(IQ_TIMEOUT - 1);
          end
        end
        WAIT_IQ: begin
          if (iq_valid) begin
            iq_d.i = i_val;
            iq_d.q = q_val;
          end else if (tmr_zero_c) begin
            error_d = 1'b1;
          end
        end
        EMIT: begin
          if (shot_ready) begin
            if (last_shot_c) done_d = 1'b1;
            else             idx_d  = shot_idx + SHOT_W'(1);
          end
        end
        default: ;
      endcase
    end
    start_collect_d = (state_d == COLLECT) && (state_q != COLLECT);
    collecting_d    = (state_d == COLLECT);
    shot_valid_d    = (state_d == EMIT);
    busy_d          = (state_d != IDLE);
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      delay_q       <= '0;
      len_q         <= '0;
      shots_q       <= '0;
      iq_q          <= '0;
      shot_idx      <= '0;
      start_collect <= 1'b0;
      collecting    <= 1'b0;
      shot_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      delay_q       <= delay_d;
      len_q         <= len_d;
      shots_q       <= shots_d;
      iq_q          <= iq_d;
      shot_idx      <= idx_d;
      start_collect <= start_collect_d;
      collecting    <= collecting_d;
      shot_valid    <= shot_valid_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
    end
  end

  assign shot_i = iq_q.i;
  assign shot_q = iq_q.q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer; shot results are checked by a scoreboard monitor.
module tb_readout_sequencer;
  import readout_pkg::*;

  logic        clk100 = 1'b0;
  logic        reset;
  logic        arm, abort, trigger;
  logic [13:0] delay_time;
  logic [10:0] sample_length;
  logic [15:0] num_shots;
  logic        iq_valid;
  logic [31:0] i_val, q_val;
  logic        start_collect, collecting, shot_valid, shot_ready;
  logic [31:0] shot_i, shot_q;
  logic [15:0] shot_idx;
  logic        busy, done, error;

  typedef struct {
    logic [31:0] i;
    logic [31:0] q;
    logic [15:0] idx;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk100 = ~clk100;

  readout_sequencer dut (
    .clk100       (clk100),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .trigger      (trigger),
    .delay_time   (delay_time),
    .sample_length(sample_length),
    .num_shots    (num_shots),
    .iq_valid     (iq_valid),
    .i_val        (i_val),
    .q_val        (q_val),
    .start_collect(start_collect),
    .collecting   (collecting),
    .shot_valid   (shot_valid),
    .shot_ready   (shot_ready),
    .shot_i       (shot_i),
    .shot_q       (shot_q),
    .shot_idx     (shot_idx),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted shot must match the next expected result.
  always @(negedge clk100) begin : monitor
    exp_t e;
    if (!reset && shot_valid && shot_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_shot", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_shot_i", shot_i, e.i);
        check("sb_shot_q", shot_q, e.q);
        check("sb_shot_idx", shot_idx, e.idx);
      end
    end
  end

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic do_arm(input logic [15:0] n, input logic [13:0] d, input logic [10:0] l);
    num_shots = n; delay_time = d; sample_length = l;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Trigger, then measure trigger-to-start latency and collect window length.
  task automatic run_collect(input string tag, input int exp_lat, input int exp_len, input bit noisy);
    int cnt;
    int sc;
    trigger = 1'b1;
    step();
    if (!noisy) trigger = 1'b0;
    cnt = 0;
    while (!start_collect && cnt < 200) begin
      step();
      cnt++;
    end
    check({tag, "_latency"}, cnt, exp_lat);
    cnt = 0;
    sc  = 0;
    while (collecting && cnt < 5000) begin
      if (start_collect) sc++;
      step();
      cnt++;
    end
    trigger = 1'b0;
    check({tag, "_collect_len"}, cnt, exp_len);
    check({tag, "_start_pulses"}, sc, 1);
  endtask

  task automatic give_iq(input string tag, input logic [31:0] i, input logic [31:0] q,
                         input logic [15:0] idx);
    exp_t e;
    e.i = i; e.q = q; e.idx = idx;
    sb.push_back(e);
    i_val = i; q_val = q; iq_valid = 1'b1;
    step();
    iq_valid = 1'b0;
    check({tag, "_shot_valid"}, shot_valid, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stim
    bit stable;
    bit nodone;
    int cnt;
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    delay_time = '0; sample_length = '0; num_shots = '0;
    iq_valid = 1'b0; i_val = '0; q_val = '0; shot_ready = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_shot_valid", shot_valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_collecting", collecting, 0);
    check("rst_shot_idx", shot_idx, 0);
    reset = 1'b0;
    step();

    // Two-shot run, delay 5, length 10
    do_arm(16'd2, 14'd5, 11'd10);
    check("a_busy_after_arm", busy, 1);
    i_val = 32'd999; q_val = 32'd999; iq_valid = 1'b1;
    step();
    iq_valid = 1'b0;
    check("a_iq_ignored_valid", shot_valid, 0);
    check("a_iq_ignored_data", shot_i, 0);
    run_collect("a0", 5, 10, 1'b0);
    give_iq("a0", 32'd100, 32'hFFFF_FFCE, 16'd0);
    check("a0_idx", shot_idx, 0);
    check("a0_i", shot_i, 100);
    check("a0_q", shot_q, 64'hFFFF_FFCE);
    stable = 1'b1;
    repeat (20) begin
      step();
      if (!shot_valid || shot_i !== 32'd100 || shot_q !== 32'hFFFF_FFCE || shot_idx !== 16'd0)
        stable = 1'b0;
    end
    check("a0_emit_stable", stable, 1);
    shot_ready = 1'b1;
    step();
    shot_ready = 1'b0;
    check("a0_hs_valid_low", shot_valid, 0);
    check("a0_hs_idx", shot_idx, 1);
    check("a0_hs_busy", busy, 1);
    check("a0_hs_no_done", done, 0);
    shot_ready = 1'b1;
    repeat (3) step();
    shot_ready = 1'b0;
    check("a_ready_no_valid_idx", shot_idx, 1);
    do_arm(16'd5, 14'd0, 11'd0);
    check("a_arm_busy_ignored", busy, 1);
    run_collect("a1", 5, 10, 1'b1);
    give_iq("a1", 32'd7, 32'd8, 16'd1);
    shot_ready = 1'b1;
    step();
    shot_ready = 1'b0;
    check("a1_done", done, 1);
    check("a1_busy", busy, 0);
    check("a1_valid_low", shot_valid, 0);
    step();
    check("a1_done_pulse", done, 0);

    // Zero delay, zero length, triggers during collect ignored
    do_arm(16'd1, 14'd0, 11'd0);
    run_collect("b", 0, 1, 1'b1);
    give_iq("b", 32'hDEAD_BEEF, 32'h1234_5678, 16'd0);
    shot_ready = 1'b1;
    step();
    shot_ready = 1'b0;
    check("b_done", done, 1);
    check("b_busy", busy, 0);

    // IQ timeout
    do_arm(16'd1, 14'd2, 11'd3);
    run_collect("c", 2, 3, 1'b0);
    nodone = 1'b1;
    repeat (63) begin
      if (done) nodone = 1'b0;
      step();
    end
    check("c_error_before", error, 0);
    check("c_busy_before", busy, 1);
    step();
    check("c_error_set", error, 1);
    check("c_idle", busy, 0);
    check("c_no_done", done, 0);
    check("c_no_done_wait", nodone, 1);
    do_arm(16'd1, 14'd1, 11'd8);
    check("c_rearm_clear_err", error, 0);
    check("c_rearm_busy", busy, 1);

    // Abort mid-collect
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    cnt = 0;
    while (!collecting && cnt < 50) begin
      step();
      cnt++;
    end
    repeat (3) step();
    check("d_collecting", collecting, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("d_abort_busy", busy, 0);
    check("d_abort_collecting", collecting, 0);
    check("d_abort_start", start_collect, 0);
    check("d_abort_done", done, 0);
    step();
    check("d_abort_done_later", done, 0);
    abort = 1'b1; arm = 1'b1; num_shots = 16'd1;
    step();
    abort = 1'b0; arm = 1'b0;
    check("d_abort_beats_arm", busy, 0);

    // Reset during EMIT with ready asserted
    do_arm(16'd3, 14'd0, 11'd2);
    run_collect("e", 0, 2, 1'b0);
    i_val = 32'd55; q_val = 32'd66; iq_valid = 1'b1;
    step();
    iq_valid = 1'b0;
    check("e_shot_valid", shot_valid, 1);
    reset = 1'b1; shot_ready = 1'b1;
    step();
    check("e_rst_valid", shot_valid, 0);
    check("e_rst_i", shot_i, 0);
    check("e_rst_q", shot_q, 0);
    check("e_rst_idx", shot_idx, 0);
    check("e_rst_busy", busy, 0);
    check("e_rst_done", done, 0);
    reset = 1'b0; shot_ready = 1'b0;
    step();

    // num_shots = 0
    do_arm(16'd0, 14'd3, 11'd3);
    check("f_done", done, 1);
    check("f_busy", busy, 0);
    step();
    check("f_done_pulse", done, 0);
    check("f_busy_later", busy, 0);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 Parameters SHALL be:
- DELAY_W, 14, delay counter width
- LEN_W, 11, sample-length width
- SHOT_W, 16, shot-count width
- IQ_TIMEOUT, 64, max cycles waiting for iq_valid
REQ-002 Ports SHALL be:
- clk100  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- arm  in  1  start a run of num_shots shots (pulse)
- abort  in  1  terminate run (pulse)
- trigger  in  1  external shot trigger
- delay_time  in  DELAY_W  trigger-to-collect delay, cycles
- sample_length  in  LEN_W  collect window, cycles
- num_shots  in  SHOT_W  shots per run
- iq_valid  in  1  integrator result strobe
- i_val, q_val  in  32 each  integrator results
- start_collect  out  1  one-cycle pulse to sampler/integrator
- collecting  out  1  high during collect window
- shot_valid  out  1  result available
- shot_ready  in  1  consumer accepts result
- shot_i, shot_q  out  32 each  captured result
- shot_idx  out  SHOT_W  index of current shot
- busy  out  1  high when not IDLE; config inputs ignored while high
- done  out  1  one-cycle pulse, run complete
- error  out  1  sticky IQ timeout flag

Function
REQ-003 FSM states SHALL be IDLE, WAIT_TRIG, DELAY, COLLECT, WAIT_IQ, EMIT.
REQ-004 In IDLE, arm SHALL latch delay_time, sample_length, num_shots, clear shot_idx and error, and enter WAIT_TRIG; num_shots=0 SHALL instead pulse done next cycle and stay IDLE.
REQ-005 Trigger SHALL be sampled only in WAIT_TRIG; triggers in other states SHALL be ignored.
REQ-006 Trigger at cycle T SHALL produce start_collect high exactly at cycle T+1+latched delay (delay 0 -> T+1).
REQ-007 collecting SHALL be high for exactly max(sample_length,1) cycles starting the cycle of start_collect; FSM then enters WAIT_IQ.
REQ-008 In WAIT_IQ, iq_valid SHALL capture i_val/q_val into shot_i/shot_q and enter EMIT next cycle; iq_valid in any other state SHALL be ignored.
REQ-009 WAIT_IQ lasting IQ_TIMEOUT cycles without iq_valid SHALL set error, end the run without done, and return to IDLE.
REQ-010 In EMIT, shot_valid SHALL stay high with shot_i, shot_q, shot_idx stable until the cycle shot_valid&&shot_ready.
REQ-011 On handshake, if shot_idx == num_shots-1 then done SHALL pulse and FSM enter IDLE; else shot_idx SHALL increment (no wrap, bounded by num_shots) and FSM enter WAIT_TRIG.
REQ-012 shot_ready high with shot_valid low SHALL have no effect.
REQ-013 abort SHALL force IDLE the next cycle from any state, deassert shot_valid, collecting, start_collect, not pulse done, keep error; abort with arm simultaneously: abort wins.
REQ-014 arm while busy SHALL be ignored.
REQ-015 Delay and collect counters SHALL be wide enough to never wrap for maximum parameter values.

Reset
REQ-016 reset SHALL force IDLE; start_collect, collecting, shot_valid, done, error, busy = 0; shot_i, shot_q, shot_idx = 0; latched config = 0.
REQ-017 reset SHALL take priority over abort, arm, and all handshakes, including mid-COLLECT and mid-EMIT.

Structure
REQ-018 State enum, DELAY_W/LEN_W/SHOT_W and IQ_TIMEOUT defaults SHALL live in shared package readout_pkg.
REQ-019 One sub-module readout_timer (loadable down-counter with zero flag) SHALL serve DELAY, COLLECT and WAIT_IQ timeout.

Verification
REQ-020 arm, num_shots=2, delay=5, length=10; trigger at T -> start_collect at T+6, collecting 10 cycles; iq_valid with i=100,q=-50 -> shot_valid, idx=0, data 100/-50.
REQ-021 shot_ready held low 20 cycles in EMIT -> outputs stable; ready at cycle 21 -> idx 1; second shot accepted -> done pulse, busy 0.
REQ-022 delay=0, length=0 -> start_collect at T+1, collecting 1 cycle; trigger during DELAY/COLLECT ignored.
REQ-023 No iq_valid for 64 cycles -> error=1, IDLE, no done; next arm clears error.
REQ-024 abort mid-COLLECT -> IDLE next cycle, collecting 0, no done; reset mid-EMIT -> all outputs zero next cycle.
REQ-025 arm with num_shots=0 -> done next cycle, busy never high; arm while busy -> no config change.
